// File: rtl/sha512_round_core.sv
// Iterative SHA-512 compression core: one round per accepted W[t]/K[t] word,
// then a chaining-value add and a valid/ready digest hand-off.
module sha512_round_core #(
    parameter int DATA_WIDTH = 64,
    parameter int ROUNDS     = 80
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [8*DATA_WIDTH-1:0]   h_in,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic [DATA_WIDTH-1:0]     k_data,
    output logic                      busy,
    output logic                      digest_valid,
    input  logic                      digest_ready,
    output logic [8*DATA_WIDTH-1:0]   digest
);
    // state | meaning
    // IDLE  | waiting for start; h_in sampled on the accepting cycle
    // ROUND | one round applied per accepted w_valid beat, bubbles hold state
    // ADD   | single cycle: digest <= saved H + working variables
    // DONE  | digest offered until digest_ready
    localparam int CW = $clog2(ROUNDS);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

    state_t            state, state_nxt;
    logic [DW-1:0]     a, b, c, d, e, f, g, h;
    logic [8*DW-1:0]   saved_h;
    logic [CW-1:0]     round_cnt;
    logic [8*DW-1:0]   working;
    logic [8*DW-1:0]   sum_vec;
    logic [DW-1:0]     s0, s1, ch, t1, t2;
    logic              accept;
    logic              round_last;

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input int n);
        return (x >> n) | (x << (DW - n));
    endfunction

    function automatic logic [DW-1:0] maj(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic [DW-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    assign accept     = (state == ROUND) && w_valid;
    assign round_last = (round_cnt == CW'(ROUNDS - 1));
    assign working    = {a, b, c, d, e, f, g, h};

    always_comb begin
        s1 = rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41);
        ch = (e & f) ^ (~e & g);
        t1 = h + s1 + ch + k_data + w_data;
        s0 = rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39);
        t2 = s0 + maj(a, b, c);
    end

    // Lane-wise add so carries never cross 64-bit word boundaries.
    always_comb begin
        sum_vec = '0;
        for (int i = 0; i < 8; i++)
            sum_vec[i*DW +: DW] = saved_h[i*DW +: DW] + working[i*DW +: DW];
    end

    always_comb begin
        state_nxt    = state;
        w_ready      = 1'b0;
        busy         = 1'b1;
        digest_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ROUND;
            end
            ROUND: begin
                w_ready = 1'b1;
                if (w_valid && round_last) state_nxt = ADD;
            end
            ADD: state_nxt = DONE;
            DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            {a, b, c, d, e, f, g, h} <= '0;
            saved_h   <= '0;
            round_cnt <= '0;
            digest    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                {a, b, c, d, e, f, g, h} <= h_in;
                saved_h   <= h_in;
                round_cnt <= '0;
            end
            if (accept) begin
                h <= g;
                g <= f;
                f <= e;
                e <= d + t1;
                d <= c;
                c <= b;
                b <= a;
                a <= t1 + t2;
                round_cnt <= round_cnt + 1'b1;
            end
            if (state == ADD)
                digest <= sum_vec;
        end
    end

endmodule

// File: doc/sha512_round_core.md
Name: sha512_round_core

Overview:
- Iterative SHA-512 compression engine that consumes one 64-bit message-schedule word W[t] and round constant K[t] per round.
- Keeps working variables a..h and applies the round function, using Majority on (a,b,c) for T2.
- After the last round it adds the chaining value and presents the 512-bit digest with a valid/ready handshake.
- Sits between the message-schedule/constant source (upstream) and the digest collector (downstream) in the hash compute unit.

Parameters:
- DATA_WIDTH, 64, word width. Only 64 is supported (SHA-512 rotation amounts).
- ROUNDS, 80, rounds per block. Counter width is clog2(ROUNDS).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a block; sampled only in IDLE
- h_in  input  8*DATA_WIDTH  chaining value; [511:448]=H0 ... [63:0]=H7
- w_valid  input  1  w_data/k_data valid
- w_ready  output  1  core accepts a round word this cycle
- w_data  input  DATA_WIDTH  message-schedule word W[t]
- k_data  input  DATA_WIDTH  round constant K[t]
- busy  output  1  high in every state except IDLE
- digest_valid  output  1  digest stable and offered
- digest_ready  input  1  downstream accepts digest
- digest  output  8*DATA_WIDTH  H+working; same packing as h_in

Behaviour:
- Reset (async assert, deassert synchronized externally): state=IDLE; a..h, saved H, round counter and digest all 0; w_ready=0, busy=0, digest_valid=0.
- States:
  - IDLE: if start, load a..h and saved H from h_in, clear counter, go to ROUND. Otherwise hold.
  - ROUND: w_ready=1. On w_valid&&w_ready, apply one round and increment the counter. If the accepted word was round ROUNDS-1, go to ADD. With no w_valid, hold all state (bubbles allowed).
  - ADD: one cycle. digest[i] = saved H[i] + working[i], each mod 2^64. Go to DONE. w_ready=0.
  - DONE: digest_valid=1. digest and digest_valid hold until digest_ready. On digest_ready, go to IDLE; digest_valid drops the next cycle. The digest register keeps its value afterwards.
- Round function, all additions mod 2^64 (truncate carries):
  - S1 = ROTR14(e)^ROTR18(e)^ROTR41(e)
  - Ch = (e&f)^(~e&g)
  - T1 = h+S1+Ch+k_data+w_data
  - S0 = ROTR28(a)^ROTR34(a)^ROTR39(a)
  - T2 = S0+Maj(a,b,c), with Maj provided by the existing Majority block
  - Update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
- Latency: start in cycle 0 with w_valid held high gives ROUND in cycles 1..80, ADD in cycle 81, digest_valid=1 in cycle 82. Each cycle of w_valid=0 adds one cycle.
- start outside IDLE is ignored; no restart mid-block.
- start and digest_ready together in DONE: only digest_ready takes effect. The new start must be reasserted in IDLE.
- w_valid outside ROUND is not consumed; w_ready=0 there.
- Reset mid-block aborts immediately to the reset values above; the partial result is discarded.
- h_in is sampled only on the accepting start cycle. Later changes have no effect.

Test Plan:
- "abc" block: drive the FIPS IV (H0=6a09e667f3bcc908 ... H7=5be0cd19137e2179), then W[0..79] and K[0..79] from the software model with w_valid=1 constant. Required: digest = ddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f, with digest_valid rising exactly 82 cycles after start.
- Bubbles: same stimulus with w_valid deasserted on a random 30% of cycles. Required: identical digest, latency 82 plus the bubble count, and the working state unchanged on every bubble cycle.
- Backpressure: hold digest_ready=0 for 10 cycles in DONE. Required: digest_valid=1 and the digest constant throughout. Pulse ready, then digest_valid=0 and busy=0 the next cycle.
- Ignored start: pulse start with h_in=all-ones during ROUND round 40. Required: "abc" digest unchanged.
- Wrap arithmetic: h_in=all FFFF_FFFF_FFFF_FFFF, W=K=FFFF_FFFF_FFFF_FFFF for all rounds. Required: digest matches the model's mod-2^64 result bit-exactly.
- Reset mid-operation: assert rst in round 37. Required: immediately busy=0, w_ready=0, digest_valid=0. A following clean "abc" run gives the correct digest.
